modulo_mux4_1_tdm: RTL and testbench

MODULO_MUX4_1_TDM -- requirements
Module: modulo_mux4_1_tdm

---
 rtl/modulo_mux4_1_tdm.sv | 101 ++++++++++
 tb/tb_modulo_mux4_1_tdm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_mux4_1_tdm.sv
// Four-channel time-division multiplexer driving a 1:4 demux.
// Each frame is four slots of SLOT_CYCLES clocks. The slot order is input_sel 00, 01, 10, 11,
// which carries in[3], in[2], in[1], in[0] in that order.
// A snapshot of the inputs is taken at the start of each frame and held for the whole frame.
module modulo_mux4_1_tdm #(
  parameter int unsigned SLOT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] in,
  output logic       A,
  output logic [1:0] input_sel,
  output logic       valid,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  // Last value of the per-slot counter; SLOT_CYCLES is at most 16, so 4 bits are enough.
  localparam logic [3:0] SlotLast = 4'(SLOT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] snap_q, snap_d;
  logic       fstart_q, fstart_d;
  logic [7:0] fcnt_q, fcnt_d;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      snap_q   <= '0;
      fstart_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      snap_q   <= snap_d;
      fstart_q <= fstart_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Next-state logic: slot counting, frame wrap and back-to-back frame restart.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    snap_d   = snap_q;
    fstart_d = 1'b0;
    fcnt_d   = fcnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StScan;
          snap_d   = in;
          sel_d    = 2'd0;
          cnt_d    = '0;
          fstart_d = 1'b1;
        end
      end
      StScan: begin
        if (cnt_q == SlotLast) begin
          cnt_d = '0;
          if (sel_q == 2'd3) begin
            // End of frame. The frame always completes, and enable only decides what follows.
            fcnt_d = fcnt_q + 8'd1;
            sel_d  = 2'd0;
            if (enable) begin
              snap_d   = in;
              fstart_d = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded only from registers. Inverting the select maps 00 to in[3].
  always_comb begin
    valid       = (state_q == StScan);
    input_sel   = sel_q;
    frame_start = fstart_q;
    frame_count = fcnt_q;
    A           = valid ? snap_q[~sel_q] : 1'b0;
  end

endmodule

// File: tb/tb_modulo_mux4_1_tdm.sv
// Bench for modulo_mux4_1_tdm. It runs two instances side by side, one with SLOT_CYCLES=4 and
// one with SLOT_CYCLES=1. A frame-position model predicts the outputs on every cycle.
module tb_modulo_mux4_1_tdm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] in = 4'd0;

  logic [1:0]      a_o;
  logic [1:0][1:0] sel_o;
  logic [1:0]      valid_o;
  logic [1:0]      fs_o;
  logic [1:0][7:0] fc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  modulo_mux4_1_tdm #(.SLOT_CYCLES(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in          (in),
    .A           (a_o[0]),
    .input_sel   (sel_o[0]),
    .valid       (valid_o[0]),
    .frame_start (fs_o[0]),
    .frame_count (fc_o[0])
  );

  modulo_mux4_1_tdm #(.SLOT_CYCLES(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in          (in),
    .A           (a_o[1]),
    .input_sel   (sel_o[1]),
    .valid       (valid_o[1]),
    .frame_start (fs_o[1]),
    .frame_count (fc_o[1])
  );

  // 1:4 demux on the SLOT_CYCLES=4 instance: select 00 drives out[3], and 11 drives out[0].
  logic [3:0] dmx;
  always_comb begin
    dmx = 4'd0;
    case (sel_o[0])
      2'd0: dmx[3] = a_o[0];
      2'd1: dmx[2] = a_o[0];
      2'd2: dmx[1] = a_o[0];
      default: dmx[0] = a_o[0];
    endcase
  end

  // Model state: whether a frame is active, the cycle position within the frame (0 to 4*S-1),
  // the frame's captured inputs, and the number of completed frames.
  int         slot_len [2] = '{4, 1};
  bit         m_active [2];
  int         m_pos    [2];
  logic [3:0] m_snap   [2];
  int         m_fc     [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_pos[i]    = 0;
      m_snap[i]   = 4'd0;
      m_fc[i]     = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!m_active[i]) begin
        if (enable) begin
          m_active[i] = 1'b1;
          m_pos[i]    = 0;
          m_snap[i]   = in;
        end
      end else if (m_pos[i] == 4 * slot_len[i] - 1) begin
        m_fc[i] = (m_fc[i] + 1) % 256;
        if (enable) begin
          m_pos[i]  = 0;
          m_snap[i] = in;
        end else begin
          m_active[i] = 1'b0;
        end
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int         sel;
    logic [3:0] snap;
    logic       a;
    for (int i = 0; i < 2; i++) begin
      sel  = m_active[i] ? m_pos[i] / slot_len[i] : 0;
      snap = m_snap[i];
      a    = m_active[i] ? snap[3 - sel] : 1'b0;
      check($sformatf("valid[%0d]", i), 32'(valid_o[i]), 32'(m_active[i]));
      check($sformatf("input_sel[%0d]", i), 32'(sel_o[i]), 32'(sel));
      check($sformatf("A[%0d]", i), 32'(a_o[i]), 32'(a));
      check($sformatf("frame_start[%0d]", i), 32'(fs_o[i]),
            32'(m_active[i] && m_pos[i] == 0));
      check($sformatf("frame_count[%0d]", i), 32'(fc_o[i]), 32'(m_fc[i]));
      if (i == 0) check("demux", 32'(dmx), 32'({1'b0, a} << (3 - sel)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] cap;

    // Reset state is checked while reset is held.
    model_reset();
    #1;
    compare_all();
    step();
    #2 rst = 1'b0;

    // Single frame with in=1010 and enable held for one cycle.
    in = 4'b1010;
    enable = 1'b1;
    step();
    enable = 1'b0;
    in = 4'b0101;
    repeat (20) step();
    check("single_frame_count", 32'(fc_o[0]), 32'd1);

    // Back-to-back frames. The input changes mid-frame, which must not affect frame 1.
    enable = 1'b1;
    in = 4'b1100;
    repeat (6) step();
    in = 4'b0011;
    repeat (40) step();
    enable = 1'b0;
    repeat (20) step();

    // Enable is dropped during the fifth cycle of a frame, and the frame must still complete.
    enable = 1'b1;
    in = 4'($urandom);
    step();
    repeat (4) step();
    enable = 1'b0;
    repeat (20) step();

    // Reset is asserted asynchronously between edges, ten cycles into a frame.
    rst = 1'b1;
    #1 step();
    #2 rst = 1'b0;
    in = 4'b1011;
    enable = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 rst = 1'b0;
    repeat (5) step();
    check("post_reset_idle", 32'(valid_o[0]), 32'd0);

    // Random enable and input traffic.
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      in = 4'($urandom);
      step();
    end
    enable = 1'b0;
    repeat (20) step();

    // Frame-count wrap on the SLOT_CYCLES=1 instance after 256 frames.
    rst = 1'b1;
    step();
    #2 rst = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 1021; k++) begin
      in = 4'($urandom);
      step();
    end
    check("wrap_fc_255", 32'(fc_o[1]), 32'd255);
    repeat (4) step();
    check("wrap_fc_0", 32'(fc_o[1]), 32'd0);
    enable = 1'b0;
    repeat (20) step();

    // Loopback through the demux: with in=0110, each demux output shows its channel bit.
    in = 4'b0110;
    enable = 1'b1;
    cap = 4'd0;
    step();
    cap |= dmx;
    enable = 1'b0;
    in = 4'b1001;
    repeat (15) begin
      step();
      cap |= dmx;
    end
    check("loopback", 32'(cap), 32'b0110);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
